// File: rtl/noc_siggen_checker.sv
// Receive-side checker for the signal-generator stream: length/seqnum checks, packet/error counters.
// Optional per-packet I^2+Q^2 power accumulator enabled by defining NOC_SIGGEN_CHECK_POWER_EN.
module noc_siggen_checker #(
  parameter int SR_CHK_ENABLE = 160,
  parameter int SR_CHK_CLEAR  = 161,
  parameter int CNT_WIDTH     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         set_stb,
  input  logic [7:0]   set_addr,
  input  logic [31:0]  set_data,
  input  logic [31:0]  i_tdata,
  input  logic [127:0] i_tuser,
  input  logic         i_tlast,
  input  logic         i_tvalid,
  output logic         i_tready,
  input  logic [7:0]   rb_addr,
  output logic [63:0]  rb_data,
  output logic         err_stb
);
  typedef enum logic {S_HDR, S_BODY} state_t;

  state_t               state;
  logic                 enable, armed, lat_eob;
  logic [11:0]          lat_seq, last_seq;
  logic [15:0]          lat_exp, cnt, cnt_last_pkt;
  logic [CNT_WIDTH-1:0] pkt_count, eob_count, seq_err_count, len_err_count;

  logic        clr, beat, len_err, seq_err, cur_eob;
  logic [11:0] hdr_seq, cur_seq;
  logic [15:0] hdr_exp, cur_exp, cur_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign i_tready = ~reset;
  assign clr      = clear | (set_stb && set_addr == 8'(SR_CHK_CLEAR));
  assign beat     = i_tvalid & i_tready & enable & ~clr;
  assign hdr_seq  = i_tuser[123:112];
  assign hdr_exp  = (i_tuser[111:96] - 16'd8 - (i_tuser[125] ? 16'd8 : 16'd0)) >> 2;

  // First beat uses the live header so a 1-sample packet is checked in the same cycle.
  always_comb begin
    cur_seq = lat_seq;
    cur_exp = lat_exp;
    cur_eob = lat_eob;
    cur_cnt = (&cnt) ? cnt : cnt + 16'd1;
    if (state == S_HDR) begin
      cur_seq = hdr_seq;
      cur_exp = hdr_exp;
      cur_eob = i_tuser[124];
      cur_cnt = 16'd1;
    end
  end

  assign len_err = (cur_cnt != cur_exp);
  assign seq_err = armed && (cur_seq != last_seq + 12'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_HDR;
      enable        <= 1'b0;
      armed         <= 1'b0;
      lat_eob       <= 1'b0;
      lat_seq       <= '0;
      last_seq      <= '0;
      lat_exp       <= '0;
      cnt           <= '0;
      cnt_last_pkt  <= '0;
      pkt_count     <= '0;
      eob_count     <= '0;
      seq_err_count <= '0;
      len_err_count <= '0;
      err_stb       <= 1'b0;
    end else begin
      err_stb <= 1'b0;
      if (set_stb && set_addr == 8'(SR_CHK_ENABLE)) enable <= set_data[0];
      if (clr) begin
        state         <= S_HDR;
        armed         <= 1'b0;
        last_seq      <= '0;
        cnt           <= '0;
        cnt_last_pkt  <= '0;
        pkt_count     <= '0;
        eob_count     <= '0;
        seq_err_count <= '0;
        len_err_count <= '0;
      end else if (!enable) begin
        state <= S_HDR;
      end else if (beat) begin
        cnt <= cur_cnt;
        if (state == S_HDR) begin
          lat_seq <= hdr_seq;
          lat_exp <= hdr_exp;
          lat_eob <= i_tuser[124];
        end
        state <= i_tlast ? S_HDR : S_BODY;
        if (i_tlast) begin
          pkt_count    <= sat_inc(pkt_count);
          cnt_last_pkt <= cur_cnt;
          last_seq     <= cur_seq;
          armed        <= ~cur_eob;
          err_stb      <= len_err | seq_err;
          if (cur_eob) eob_count     <= sat_inc(eob_count);
          if (len_err) len_err_count <= sat_inc(len_err_count);
          if (seq_err) seq_err_count <= sat_inc(seq_err_count);
        end
      end
    end
  end

`ifdef NOC_SIGGEN_CHECK_POWER_EN
  logic signed [31:0] pi, pq;
  logic [31:0] sq;
  logic        v1, first1, last1;
  logic [47:0] acc, pwr_last, acc_nxt;
  logic [48:0] acc_sum;

  assign pi      = $signed(i_tdata[31:16]) * $signed(i_tdata[31:16]);
  assign pq      = $signed(i_tdata[15:0])  * $signed(i_tdata[15:0]);
  assign acc_sum = (first1 ? 49'd0 : {1'b0, acc}) + {17'd0, sq};
  assign acc_nxt = acc_sum[48] ? '1 : acc_sum[47:0];

  // Stage 1 registers the squares, stage 2 accumulates and latches at packet end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sq <= '0; v1 <= 1'b0; first1 <= 1'b0; last1 <= 1'b0;
      acc <= '0; pwr_last <= '0;
    end else if (clr) begin
      v1 <= 1'b0; acc <= '0; pwr_last <= '0;
    end else begin
      v1     <= beat;
      sq     <= pi + pq;
      first1 <= (state == S_HDR);
      last1  <= i_tlast;
      if (v1) begin
        acc <= acc_nxt;
        if (last1) pwr_last <= acc_nxt;
      end
    end
  end

  logic unused;
  assign unused = &{1'b0, i_tuser[127:126], i_tuser[95:0], set_data[31:1]};
`else
  logic unused;
  assign unused = &{1'b0, i_tuser[127:126], i_tuser[95:0], set_data[31:1], i_tdata};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rb_data <= '0;
    else begin
      case (rb_addr)
        8'd0:    rb_data <= {32'(pkt_count), 32'(eob_count)};
        8'd1:    rb_data <= {32'(seq_err_count), 32'(len_err_count)};
        8'd2:    rb_data <= {32'd0, 4'd0, last_seq, cnt_last_pkt};
`ifdef NOC_SIGGEN_CHECK_POWER_EN
        8'd3:    rb_data <= {16'd0, pwr_last};
`endif
        default: rb_data <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_noc_siggen_checker.sv
// Randomized bench for noc_siggen_checker against a packet-level reference model.
module tb_noc_siggen_checker;
  logic         clk = 1'b0, reset, clear, set_stb, i_tlast, i_tvalid, i_tready, err_stb;
  logic [7:0]   set_addr, rb_addr;
  logic [31:0]  set_data, i_tdata;
  logic [127:0] i_tuser;
  logic [63:0]  rb_data, d;

  noc_siggen_checker dut (
    .clk(clk), .reset(reset), .clear(clear), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready), .rb_addr(rb_addr), .rb_data(rb_data),
    .err_stb(err_stb)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, pulses = 0, m_errpk = 0;
  longint m_pkt, m_eob, m_seqe, m_lene, m_pwr;
  int m_last, m_cnt;
  bit m_armed, m_en, m_pwr_ok;

  always @(negedge clk) if (err_stb === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic model_clear;
    m_pkt = 0; m_eob = 0; m_seqe = 0; m_lene = 0; m_last = 0; m_cnt = 0;
    m_armed = 0; m_pwr_ok = 0;
  endtask

  task automatic wr(input int a, input int v);
    set_stb = 1'b1; set_addr = 8'(a); set_data = 32'(v);
    step;
    set_stb = 1'b0;
  endtask

  task automatic rd(input int a, output logic [63:0] q);
    rb_addr = 8'(a);
    step;
    q = rb_data;
  endtask

  task automatic check_all(input string tag);
    logic [63:0] q;
    rd(0, q); chk({tag, " rb0"}, q, {m_pkt[31:0], m_eob[31:0]});
    rd(1, q); chk({tag, " rb1"}, q, {m_seqe[31:0], m_lene[31:0]});
    rd(2, q); chk({tag, " rb2"}, q, {36'd0, 12'(m_last), 16'(m_cnt)});
    rd(3, q);
`ifdef NOC_SIGGEN_CHECK_POWER_EN
    if (m_pwr_ok) chk({tag, " rb3"}, q, {16'd0, m_pwr[47:0]});
`else
    chk({tag, " rb3"}, q, 64'd0);
`endif
  endtask

  // decl = declared samples (len_bytes derived from it), nbeats = beats actually sent.
  task automatic send_pkt(input int seq, input int decl, input int nbeats, input bit ht,
                          input bit eob, input bit fixed, input logic [31:0] fval,
                          input bit clr_last, input string tag);
    logic [127:0] hdr;
    longint psum;
    int len, ii, qq;
    bit le, se, err;
    psum = 0;
    len = 8 + 8*ht + 4*decl;
    hdr = {$urandom, $urandom, $urandom, $urandom};
    hdr[125] = ht; hdr[124] = eob; hdr[123:112] = 12'(seq); hdr[111:96] = 16'(len);
    for (int b = 0; b < nbeats; b++) begin
      while ($urandom_range(3) == 0) begin i_tvalid = 1'b0; step; end
      i_tvalid = 1'b1;
      i_tdata  = fixed ? fval : $urandom;
      hdr[63:0] = {$urandom, $urandom};
      i_tuser  = hdr;
      i_tlast  = (b == nbeats - 1);
      clear    = clr_last && (b == nbeats - 1);
      ii = $signed(i_tdata[31:16]);
      qq = $signed(i_tdata[15:0]);
      psum += longint'(ii*ii) + longint'(qq*qq);
      step;
    end
    le = (nbeats != decl);
    se = m_armed && ((seq % 4096) != ((m_last + 1) % 4096));
    err = m_en && !clr_last && (le || se);
    chk({tag, " err_stb"}, {63'd0, err_stb}, {63'd0, err});
    if (clr_last) model_clear;
    else if (m_en) begin
      m_pkt++;
      if (eob) m_eob++;
      if (le) m_lene++;
      if (se) m_seqe++;
      if (err) m_errpk++;
      m_last = seq % 4096;
      m_armed = !eob;
      m_cnt = (nbeats > 65535) ? 65535 : nbeats;
      m_pwr = (psum > 64'hFFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF : psum;
      m_pwr_ok = 1;
    end
    i_tvalid = 1'b0; i_tlast = 1'b0; clear = 1'b0;
    step;
  endtask

  initial begin
    int s, decl, nb;
    reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    i_tdata = '0; i_tuser = '0; i_tlast = 1'b0; i_tvalid = 1'b0; rb_addr = '0;
    model_clear; m_en = 0;
    step; step;
    chk("rst tready", {63'd0, i_tready}, 64'd0);
    chk("rst rb_data", rb_data, 64'd0);
    chk("rst err_stb", {63'd0, err_stb}, 64'd0);
    reset = 1'b0;
    step;
    chk("tready up", {63'd0, i_tready}, 64'd1);
    check_all("reset");

    wr(160, 1); m_en = 1;
    for (int k = 0; k < 3; k++) send_pkt(k, 4, 4, 0, 0, 0, 0, 0, "T1");
    check_all("T1");

    send_pkt(5, 4, 4, 0, 0, 0, 0, 0, "T2a");
    send_pkt(7, 4, 4, 1, 0, 0, 0, 0, "T2b");
    check_all("T2");

    send_pkt(4095, 4, 4, 0, 0, 0, 0, 0, "T3a");
    send_pkt(0, 4, 5, 0, 0, 0, 0, 0, "T3b");
    check_all("T3");

    send_pkt(9, 4, 4, 0, 1, 0, 0, 0, "T4a");
    send_pkt(0, 1, 1, 0, 0, 0, 0, 0, "T4b");
    check_all("T4");
    wr(160, 0); m_en = 0;
    send_pkt(100, 4, 3, 0, 0, 0, 0, 0, "T4dis");
    check_all("T4dis");
    wr(160, 1); m_en = 1;

    send_pkt(1, 4, 4, 0, 0, 0, 0, 1, "T5clr");
    rd(0, d); chk("T5 rb0", d, {m_pkt[31:0], m_eob[31:0]});
    rd(1, d); chk("T5 rb1", d, {m_seqe[31:0], m_lene[31:0]});
    send_pkt(300, 2, 2, 0, 0, 0, 0, 0, "T5post");
    check_all("T5post");

    // Reset in the middle of a packet.
    i_tvalid = 1'b1; i_tuser = '0; i_tuser[111:96] = 16'd24; i_tlast = 1'b0;
    step; step;
    #2 reset = 1'b1;
    #1 chk("T5 rst tready", {63'd0, i_tready}, 64'd0);
    i_tvalid = 1'b0;
    step;
    reset = 1'b0; model_clear; m_en = 0;
    step;
    chk("T5 rst rb_data", rb_data, 64'd0);
    check_all("T5rst");
    wr(160, 1); m_en = 1;

`ifdef NOC_SIGGEN_CHECK_POWER_EN
    send_pkt(0, 4, 4, 0, 0, 1, 32'h4000_0000, 0, "T6a");
    check_all("T6a");
    chk("T6a pwr", m_pwr, 64'h4000_0000);
    send_pkt(1, 4, 4, 0, 0, 1, 32'h8000_8000, 0, "T6b");
    check_all("T6b");
    chk("T6b pwr", m_pwr, 64'h2_0000_0000);
`endif

    for (int k = 0; k < 40; k++) begin
      s = ($urandom_range(4) == 0) ? int'($urandom_range(4095)) : (m_last + 1) % 4096;
      decl = $urandom_range(1, 16);
      nb = decl;
      if ($urandom_range(4) == 0) nb = (decl > 1 && $urandom_range(1)) ? decl - 1 : decl + 1;
      send_pkt(s, decl, nb, 1'($urandom_range(1)), ($urandom_range(9) == 0), 0, 0, 0, "rnd");
      if (k % 8 == 7) check_all("rnd");
    end

    wr(161, 0); model_clear;
    rd(0, d); chk("srclr rb0", d, 64'd0);
    rd(1, d); chk("srclr rb1", d, 64'd0);
    send_pkt(77, 3, 3, 0, 0, 0, 0, 0, "srclr post");
    check_all("srclr post");

    step; step;
    chk("err pulses", 64'(pulses), 64'(m_errpk));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
